// File: rtl/exec_csr_unit.sv
// Execute-stage ALU, branch comparator and machine-mode CSR file for an RV32I core.
// Handles CSR read/modify/write, ECALL/EBREAK/MRET and trap redirection to mtvec.
module exec_csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_8000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  alu_op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [6:0]  funct7,
    input  logic [4:0]  shamt,
    input  logic        is_r_type,
    output logic [31:0] alu_out,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        is_branch_jump,
    input  logic        is_system,
    input  logic [11:0] funct12,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rd_addr,
    input  logic        illegal_instruction,
    input  logic [31:0] pc,
    output logic [31:0] csr_out,
    output logic        write_back,
    output logic        is_illegal,
    output logic [31:0] next_csr_pc,
    output logic        enable_pc_update_from_csr
);

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;

    // ---------------- ALU ----------------
    logic [4:0] shift_amt;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        alu_out   = 32'h0;
        shift_amt = is_r_type ? in2[4:0] : shamt;
        case (alu_op)
            3'b000:  alu_out = (is_r_type && funct7[5]) ? in1 - in2 : in1 + in2;
            3'b001:  alu_out = in1 << shift_amt;
            3'b010:  alu_out = {31'b0, $signed(in1) < $signed(in2)};
            3'b011:  alu_out = {31'b0, in1 < in2};
            3'b100:  alu_out = in1 ^ in2;
            3'b101:  alu_out = funct7[5] ? $unsigned($signed(in1) >>> shift_amt)
                                         : in1 >> shift_amt;
            3'b110:  alu_out = in1 | in2;
            default: alu_out = in1 & in2;
        endcase
    end

    // ---------------- Branch comparator ----------------
    always_comb begin
        is_branch_jump = 1'b0;
        case (funct3)
            3'b000:  is_branch_jump = (rs1_data == rs2_data);
            3'b001:  is_branch_jump = (rs1_data != rs2_data);
            3'b100:  is_branch_jump = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  is_branch_jump = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  is_branch_jump = (rs1_data <  rs2_data);
            3'b111:  is_branch_jump = (rs1_data >= rs2_data);
            default: is_branch_jump = 1'b0;
        endcase
    end

    // ---------------- CSR state ----------------
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie_q;
    logic [31:2] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:2] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [31:0] mcycle_q;

    logic [31:0] csr_rdata;
    logic        csr_known;
    logic        csr_ro;

    always_comb begin
        csr_rdata = 32'h0;
        csr_known = 1'b1;
        csr_ro    = 1'b0;
        case (funct12)
            CSR_MSTATUS:  csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            CSR_MISA:     begin csr_rdata = MISA_VALUE; csr_ro = 1'b1; end
            CSR_MIE:      csr_rdata = mie_q;
            CSR_MTVEC:    csr_rdata = {mtvec_q, 2'b00};
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = {mepc_q, 2'b00};
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MTVAL:    csr_rdata = mtval_q;
            CSR_MCYCLE:   csr_rdata = mcycle_q;
            CSR_MHARTID:  csr_ro = 1'b1;
            default:      csr_known = 1'b0;
        endcase
    end

    // ---------------- Decode ----------------
    logic        csr_op, csr_wr_attempt, csr_illegal, csr_legal, csr_we;
    logic        sys_zero, do_ecall, do_ebreak, do_mret, sys_bad, trap, mret_take;
    logic [31:0] csr_operand, csr_wdata, trap_cause;

    always_comb begin
        csr_op         = is_system && (funct3 != 3'b000);
        // Set/clear with a zero source is a pure read, so it is legal even on read-only CSRs.
        csr_wr_attempt = (funct3[1:0] == 2'b01) || (rs_addr != 5'd0);
        csr_illegal    = csr_op && ((funct3 == 3'b100) || !csr_known || (csr_ro && csr_wr_attempt));
        csr_legal      = csr_op && !csr_illegal && !illegal_instruction;
        csr_we         = csr_legal && csr_wr_attempt;
        csr_operand    = funct3[2] ? {27'b0, rs_addr} : rs1_data;

        csr_wdata = csr_rdata;
        case (funct3[1:0])
            2'b01:   csr_wdata = csr_operand;
            2'b10:   csr_wdata = csr_rdata | csr_operand;
            2'b11:   csr_wdata = csr_rdata & ~csr_operand;
            default: csr_wdata = csr_rdata;
        endcase

        sys_zero  = is_system && (funct3 == 3'b000);
        do_ecall  = sys_zero && (funct12 == 12'h000);
        do_ebreak = sys_zero && (funct12 == 12'h001);
        do_mret   = sys_zero && (funct12 == 12'h302);
        sys_bad   = sys_zero && !do_ecall && !do_ebreak && !do_mret;

        trap      = do_ecall || do_ebreak || sys_bad || csr_illegal || illegal_instruction;
        mret_take = do_mret && !trap;

        if (sys_bad || csr_illegal || illegal_instruction) trap_cause = CAUSE_ILLEGAL;
        else if (do_ecall)                                 trap_cause = CAUSE_ECALL;
        else                                               trap_cause = CAUSE_EBREAK;

        is_illegal  = csr_illegal;
        write_back  = csr_legal && (rd_addr != 5'd0);
        csr_out     = csr_op ? csr_rdata : 32'h0;

        enable_pc_update_from_csr = trap || mret_take;
        next_csr_pc = 32'h0;
        if (trap)           next_csr_pc = {mtvec_q, 2'b00};
        else if (mret_take) next_csr_pc = {mepc_q, 2'b00};
    end

    // ---------------- CSR update ----------------
    // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= 32'h0;
            mtvec_q      <= MTVEC_RESET[31:2];
            mscratch_q   <= 32'h0;
            mepc_q       <= 30'h0;
            mcause_q     <= 32'h0;
            mtval_q      <= 32'h0;
            mcycle_q     <= 32'h0;
        end else begin
            mcycle_q <= mcycle_q + 32'd1;
            if (csr_we) begin
                case (funct12)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= csr_wdata[3];
                        mstatus_mpie <= csr_wdata[7];
                    end
                    CSR_MIE:      mie_q      <= csr_wdata;
                    CSR_MTVEC:    mtvec_q    <= csr_wdata[31:2];
                    CSR_MSCRATCH: mscratch_q <= csr_wdata;
                    CSR_MEPC:     mepc_q     <= csr_wdata[31:2];
                    CSR_MCAUSE:   mcause_q   <= csr_wdata;
                    CSR_MTVAL:    mtval_q    <= csr_wdata;
                    CSR_MCYCLE:   mcycle_q   <= csr_wdata;
                    default: ;
                endcase
            end
            if (trap) begin
                mepc_q       <= pc[31:2];
                mcause_q     <= trap_cause;
                mtval_q      <= 32'h0;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_take) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end

    logic unused_in;
    assign unused_in = &{1'b0, funct7[6], funct7[4:0]};

endmodule

// File: tb/tb_exec_csr_unit.sv
// Randomised self-checking bench for exec_csr_unit against a behavioural CSR/ALU model.
module tb_exec_csr_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  alu_op;
    logic [31:0] in1, in2;
    logic [6:0]  funct7;
    logic [4:0]  shamt;
    logic        is_r_type;
    logic [31:0] alu_out;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic        is_branch_jump;
    logic        is_system;
    logic [11:0] funct12;
    logic [4:0]  rs_addr, rd_addr;
    logic        illegal_instruction;
    logic [31:0] pc;
    logic [31:0] csr_out;
    logic        write_back, is_illegal;
    logic [31:0] next_csr_pc;
    logic        enable_pc_update_from_csr;

    always #5 clk = ~clk;

    exec_csr_unit dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .in1(in1), .in2(in2), .funct7(funct7),
        .shamt(shamt), .is_r_type(is_r_type), .alu_out(alu_out), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .is_branch_jump(is_branch_jump),
        .is_system(is_system), .funct12(funct12), .rs_addr(rs_addr), .rd_addr(rd_addr),
        .illegal_instruction(illegal_instruction), .pc(pc), .csr_out(csr_out),
        .write_back(write_back), .is_illegal(is_illegal), .next_csr_pc(next_csr_pc),
        .enable_pc_update_from_csr(enable_pc_update_from_csr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: CSR file as a table indexed by address.
    logic [31:0] m_csr [logic [11:0]];

    localparam logic [11:0] ADDRS [10] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                                           12'h341, 12'h342, 12'h343, 12'hB00, 12'hF14};

    task automatic model_reset();
        foreach (ADDRS[i]) m_csr[ADDRS[i]] = 32'h0;
        m_csr[12'h301] = 32'h4000_0100;
        m_csr[12'h305] = 32'h0000_8000;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        if (!m_csr.exists(a)) return 32'h0;
        if (a == 12'h300) return (m_csr[a] & 32'h88) | 32'h1800;
        if (a == 12'h305 || a == 12'h341) return m_csr[a] & ~32'h3;
        return m_csr[a];
    endfunction

    function automatic logic [31:0] m_alu();
        int sh = is_r_type ? int'(in2[4:0]) : int'(shamt);
        case (alu_op)
            3'd0: return (is_r_type && funct7[5]) ? in1 - in2 : in1 + in2;
            3'd1: return in1 << sh;
            3'd2: return ($signed(in1) < $signed(in2)) ? 32'd1 : 32'd0;
            3'd3: return (in1 < in2) ? 32'd1 : 32'd0;
            3'd4: return in1 ^ in2;
            3'd5: return funct7[5] ? 32'($signed(in1) >>> sh) : in1 >> sh;
            3'd6: return in1 | in2;
            default: return in1 & in2;
        endcase
    endfunction

    function automatic logic m_branch();
        case (funct3)
            3'd0: return rs1_data == rs2_data;
            3'd1: return rs1_data != rs2_data;
            3'd4: return $signed(rs1_data) < $signed(rs2_data);
            3'd5: return $signed(rs1_data) >= $signed(rs2_data);
            3'd6: return rs1_data < rs2_data;
            3'd7: return rs1_data >= rs2_data;
            default: return 1'b0;
        endcase
    endfunction

    // Called at the falling edge with inputs applied: checks outputs, then advances model over the rising edge.
    task automatic step();
        logic        csr_op, wr_try, ill, legal, sys0, ecall, ebreak, mret, bad, trap, mret_ok;
        logic [31:0] old, opnd, newv, cause, exp_pc;
        #2;
        csr_op  = is_system && funct3 != 3'd0;
        wr_try  = funct3[1:0] == 2'b01 || rs_addr != 5'd0;
        ill     = csr_op && (funct3 == 3'd4 || !m_csr.exists(funct12) ||
                  ((funct12 == 12'h301 || funct12 == 12'hF14) && wr_try));
        legal   = csr_op && !ill && !illegal_instruction;
        sys0    = is_system && funct3 == 3'd0;
        ecall   = sys0 && funct12 == 12'h000;
        ebreak  = sys0 && funct12 == 12'h001;
        mret    = sys0 && funct12 == 12'h302;
        bad     = sys0 && !ecall && !ebreak && !mret;
        trap    = ecall || ebreak || bad || ill || illegal_instruction;
        mret_ok = mret && !trap;
        cause   = (bad || ill || illegal_instruction) ? 32'd2 : ecall ? 32'd11 : 32'd3;
        old     = m_read(funct12);
        exp_pc  = trap ? m_read(12'h305) : mret_ok ? m_read(12'h341) : 32'h0;

        check("alu_out", alu_out, m_alu());
        check("branch", 32'(is_branch_jump), 32'(m_branch()));
        check("csr_out", csr_out, csr_op ? old : 32'h0);
        check("write_back", 32'(write_back), 32'(legal && rd_addr != 5'd0));
        check("is_illegal", 32'(is_illegal), 32'(ill));
        check("pc_enable", 32'(enable_pc_update_from_csr), 32'(trap || mret_ok));
        check("next_pc", next_csr_pc, exp_pc);

        @(posedge clk);
        opnd = funct3[2] ? {27'b0, rs_addr} : rs1_data;
        case (funct3[1:0])
            2'b01:   newv = opnd;
            2'b10:   newv = old | opnd;
            default: newv = old & ~opnd;
        endcase
        if (rst) begin
            m_csr[12'hB00] = m_csr[12'hB00] + 32'd1;
            if (legal && wr_try) m_csr[funct12] = newv;
            if (trap) begin
                m_csr[12'h341] = pc;
                m_csr[12'h342] = cause;
                m_csr[12'h343] = 32'h0;
                m_csr[12'h300] = m_csr[12'h300][3] ? 32'h80 : 32'h0;
            end else if (mret_ok) begin
                m_csr[12'h300] = m_csr[12'h300][7] ? 32'h88 : 32'h80;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        alu_op = 3'd0; in1 = 32'h0; in2 = 32'h0; funct7 = 7'h0; shamt = 5'd0; is_r_type = 1'b0;
        funct3 = 3'd0; rs1_data = 32'h0; rs2_data = 32'h0; is_system = 1'b0; funct12 = 12'h0;
        rs_addr = 5'd0; rd_addr = 5'd0; illegal_instruction = 1'b0; pc = 32'h0;
    endtask

    task automatic csr(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs,
                       input logic [31:0] d, input logic [4:0] rd);
        idle();
        is_system = 1'b1; funct3 = f3; funct12 = a; rs_addr = rs; rs1_data = d; rd_addr = rd;
    endtask

    task automatic sys(input logic [11:0] f12, input logic [31:0] p);
        idle();
        is_system = 1'b1; funct12 = f12; pc = p;
    endtask

    initial begin
        idle();
        model_reset();
        csr(3'd2, 12'h305, 5'd0, 32'h0, 5'd0);
        repeat (2) @(negedge clk);
        #1 check("reset_mtvec", csr_out, 32'h0000_8000);
        rst = 1'b1;

        // Subtract and arithmetic right shift
        idle(); alu_op = 3'd0; is_r_type = 1'b1; funct7 = 7'h20; in1 = 32'd5; in2 = 32'd7;
        #1 check("sub_5_7", alu_out, 32'hFFFF_FFFE);
        step();
        idle(); alu_op = 3'd5; funct7 = 7'h20; shamt = 5'd4; in1 = 32'h8000_0000;
        #1 check("sra_imm", alu_out, 32'hF800_0000);
        step();

        // Signed vs unsigned less-than on the same data
        idle(); funct3 = 3'd4; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1;
        #1 check("blt_signed", 32'(is_branch_jump), 32'd1);
        step();
        funct3 = 3'd6;
        #1 check("bltu", 32'(is_branch_jump), 32'd0);
        step();

        // mscratch write then read-only set
        csr(3'd1, 12'h340, 5'd1, 32'h1234, 5'd5);
        #1 check("csrrw_wb", 32'(write_back), 32'd1);
        step();
        csr(3'd2, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd0);
        #1 check("csrrs_read", csr_out, 32'h1234);
        step();

        // ECALL / MRET round trip
        sys(12'h000, 32'h8010);
        #1 check("ecall_pc", next_csr_pc, 32'h8000);
        step();
        csr(3'd2, 12'h341, 5'd0, 32'h0, 5'd1);
        #1 check("mepc", csr_out, 32'h8010);
        step();
        csr(3'd2, 12'h342, 5'd0, 32'h0, 5'd1);
        #1 check("mcause_ecall", csr_out, 32'd11);
        step();
        sys(12'h302, 32'h9000);
        #1 check("mret_pc", next_csr_pc, 32'h8010);
        step();

        // Write to read-only misa
        csr(3'd1, 12'h301, 5'd2, 32'hDEAD_BEEF, 5'd3);
        #1 check("misa_illegal", 32'(is_illegal), 32'd1);
        step();
        csr(3'd2, 12'h301, 5'd0, 32'h0, 5'd3);
        #1 check("misa_kept", csr_out, 32'h4000_0100);
        step();
        csr(3'd2, 12'h342, 5'd0, 32'h0, 5'd3);
        #1 check("mcause_illegal", csr_out, 32'd2);
        step();

        // Randomised mix
        for (int i = 0; i < 600; i++) begin
            int kind = $urandom_range(0, 9);
            idle();
            alu_op = 3'($urandom); in1 = $urandom; in2 = $urandom; funct7 = 7'($urandom);
            shamt = 5'($urandom); is_r_type = 1'($urandom);
            funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
            if ($urandom_range(0, 3) == 0) rs2_data = rs1_data;
            pc = $urandom; rd_addr = 5'($urandom); rs_addr = 5'($urandom);
            if ($urandom_range(0, 3) == 0) rs_addr = 5'd0;
            illegal_instruction = ($urandom_range(0, 24) == 0);
            if (kind >= 4) begin
                is_system = 1'b1;
                if (funct3 == 3'd0) funct3 = 3'($urandom_range(1, 7));
                funct12 = ($urandom_range(0, 9) == 0) ? 12'($urandom) : ADDRS[$urandom_range(0, 9)];
            end else if (kind == 3) begin
                is_system = 1'b1; funct3 = 3'd0;
                case ($urandom_range(0, 3))
                    0: funct12 = 12'h000;
                    1: funct12 = 12'h001;
                    2: funct12 = 12'h302;
                    default: funct12 = 12'($urandom);
                endcase
            end
            step();
        end

        // Asynchronous reset mid-sequence, observed before any clock edge
        csr(3'd1, 12'h340, 5'd1, 32'hA5A5_0001, 5'd0);
        step();
        csr(3'd2, 12'h340, 5'd0, 32'h0, 5'd0);
        rst = 1'b0;
        #1 check("rst_mscratch", csr_out, 32'h0);
        funct12 = 12'h305;
        #1 check("rst_mtvec", csr_out, 32'h0000_8000);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        csr(3'd2, 12'hB00, 5'd0, 32'h0, 5'd0);
        step();
        csr(3'd2, 12'hB00, 5'd0, 32'h0, 5'd0);
        #1 check("mcycle_after_rst", csr_out, 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
